// File: rtl/pipe_types_pkg.sv
// Shared types for the pipeline sequencer: FSM states, per-stage control pair and register index type.
package pipe_types_pkg;

    localparam int REG_BITS = 5;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } pipe_ctrl_t;

    // A flushed stage must also be enabled so the bubble is actually loaded.
    function automatic pipe_ctrl_t stage_ctl(input logic en, input logic flush);
        pipe_ctrl_t c;
        c.en    = en | flush;
        c.flush = flush;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources of the instruction in IF/ID.
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    output logic            load_use
);

    // Register zero is hardwired, so a load into it never creates a dependency.
    assign load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central enable/flush/stall controller for the 5-stage core with sticky halt.
// Optional perf counters (stall/flush/dwait) are built when PIPE_PERF_EN is defined.
module pipeline_sequencer
    import pipe_types_pkg::*;
#(
    parameter int REGW = 5
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_req,
    input  logic            mem_br_taken,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            wb_halt,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic            memwb_stall,
    output logic            halt
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] dwait_cnt
`endif
);

    pipe_state_t state, next_state;
    logic        ihit_seen, ihit_seen_next;
    logic        load_use;
    logic        mem_done, fetch_ok, halting;
    pipe_ctrl_t  ifid_c, idex_c, exmem_c, memwb_c;

    hazard_detect #(.REGW(REGW)) u_hazard (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .load_use   (load_use)
    );

    // A fetch that completed while the pipe was frozen stays valid until the PC moves.
    assign mem_done = ~mem_req | dhit;
    assign fetch_ok = ihit | ihit_seen;
    assign halting  = (state == HALTED) | wb_halt;
    assign halt     = (state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            ihit_seen <= 1'b0;
        end else begin
            state     <= next_state;
            ihit_seen <= ihit_seen_next;
        end
    end

    always_comb begin
        next_state     = state;
        ihit_seen_next = ihit_seen;
        pc_en          = 1'b0;
        ifid_c         = '0;
        idex_c         = '0;
        exmem_c        = '0;
        memwb_c        = '0;
        if (!nRST) begin
            next_state     = RUN;
            ihit_seen_next = 1'b0;
        end else if (halting) begin
            next_state     = HALTED;
            ihit_seen_next = 1'b0;
        end else if (!mem_done) begin
            next_state     = DWAIT;
            ihit_seen_next = ihit_seen | ihit;
        end else begin
            next_state = RUN;
            if (!fetch_ok) begin
                ifid_c  = stage_ctl(1'b1, 1'b1);
                idex_c  = stage_ctl(1'b1, 1'b0);
                exmem_c = stage_ctl(1'b1, 1'b0);
                memwb_c = stage_ctl(1'b1, 1'b0);
            end else if (mem_br_taken) begin
                pc_en   = 1'b1;
                ifid_c  = stage_ctl(1'b1, 1'b1);
                idex_c  = stage_ctl(1'b1, 1'b1);
                exmem_c = stage_ctl(1'b1, 1'b1);
                memwb_c = stage_ctl(1'b1, 1'b0);
            end else if (load_use) begin
                idex_c  = stage_ctl(1'b1, 1'b1);
                exmem_c = stage_ctl(1'b1, 1'b0);
                memwb_c = stage_ctl(1'b1, 1'b0);
            end else begin
                pc_en   = 1'b1;
                ifid_c  = stage_ctl(1'b1, 1'b0);
                idex_c  = stage_ctl(1'b1, 1'b0);
                exmem_c = stage_ctl(1'b1, 1'b0);
                memwb_c = stage_ctl(1'b1, 1'b0);
            end
            ihit_seen_next = pc_en ? 1'b0 : (ihit_seen | ihit);
        end
    end

    assign ifid_en     = ifid_c.en;
    assign idex_en     = idex_c.en;
    assign exmem_en    = exmem_c.en;
    assign memwb_en    = memwb_c.en;
    assign ifid_flush  = ifid_c.flush;
    assign idex_flush  = idex_c.flush;
    assign exmem_flush = exmem_c.flush;
    assign memwb_flush = memwb_c.flush;
    assign memwb_stall = ~memwb_c.en;

`ifdef PIPE_PERF_EN
    logic br_flush;
    assign br_flush = ~halting & mem_done & fetch_ok & mem_br_taken;

    // Saturating counters; nothing counts once the core has halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            dwait_cnt <= '0;
        end else if (state != HALTED) begin
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if ((state == DWAIT) && (dwait_cnt != '1))
                dwait_cnt <= dwait_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer; counter checks are included when PIPE_PERF_EN is defined.
module tb_pipeline_sequencer;
    import pipe_types_pkg::*;

    // Expected vector order: pc,ifid,idex,exmem,memwb en | ifid,idex,exmem,memwb flush | memwb_stall | halt
    localparam logic [10:0] ALL_EN  = 11'b11111_0000_00;
    localparam logic [10:0] FREEZE  = 11'b00000_0000_10;
    localparam logic [10:0] NOFETCH = 11'b01111_1000_00;
    localparam logic [10:0] BRANCH  = 11'b11111_1110_00;
    localparam logic [10:0] LOADUSE = 11'b00111_0100_00;
    localparam logic [10:0] HALTD   = 11'b00000_0000_11;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } exp_t;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    logic     ihit = 1'b0, dhit = 1'b0, mem_req = 1'b0, mem_br_taken = 1'b0;
    logic     ex_memread = 1'b0, wb_halt = 1'b0;
    regbits_t ex_rt = '0, id_rs = '0, id_rt = '0;
    logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic     ifid_flush, idex_flush, exmem_flush, memwb_flush, memwb_stall, halt;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, dwait_cnt;
`endif

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 CLK = ~CLK;

    pipeline_sequencer #(
        .REGW(5)
`ifdef PIPE_PERF_EN
        , .CNT_W(32)
`endif
    ) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .mem_br_taken(mem_br_taken), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .memwb_stall(memwb_stall), .halt(halt)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue the hand-computed response.
    task automatic applyStimulus(input string name, input logic rst_v, input logic ih,
                                 input logic dh, input logic mr, input logic br,
                                 input logic mrd, input regbits_t rt, input regbits_t rs,
                                 input regbits_t rtt, input logic wh, input logic [10:0] exp);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = rst_v; ihit = ih; dhit = dh; mem_req = mr; mem_br_taken = br;
        ex_memread = mrd; ex_rt = rt; id_rs = rs; id_rt = rtt; wb_halt = wh;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

`ifdef PIPE_PERF_EN
    task automatic checkCounters(input string name, input logic [31:0] s, input logic [31:0] f,
                                 input logic [31:0] d);
        @(negedge CLK);
        checkOutput({name, "_stall"}, stall_cnt, s);
        checkOutput({name, "_flush"}, flush_cnt, f);
        checkOutput({name, "_dwait"}, dwait_cnt, d);
    endtask
`endif

    // Monitor: outputs are combinational, so every driven cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.name,
                    {21'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
                     idex_flush, exmem_flush, memwb_flush, memwb_stall, halt},
                    {21'd0, e.exp});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge CLK);
        //             name              rst ih dh mr br mrd  rt     rs     rtt   wh exp
        applyStimulus("pre_run",          1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, ALL_EN);
        applyStimulus("reset_mid_run",    0, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("run_ihit",         1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, ALL_EN);
        applyStimulus("no_ihit",          1, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, NOFETCH);
        applyStimulus("ihit_back",        1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, ALL_EN);
        applyStimulus("dwait1",           1, 1, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("dwait2",           1, 0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("dwait3",           1, 0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("dwait_done",       1, 0, 1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, ALL_EN);
        applyStimulus("seen_cleared",     1, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, NOFETCH);
`ifdef PIPE_PERF_EN
        checkCounters("cnt_dwait", 32'd4, 32'd0, 32'd3);
`endif
        applyStimulus("loaduse_rs",       1, 1, 0, 0, 0, 1, 5'd5,  5'd5,  5'd0,  0, LOADUSE);
        applyStimulus("loaduse_rt_seen",  1, 0, 0, 0, 0, 1, 5'd5,  5'd3,  5'd5,  0, LOADUSE);
        applyStimulus("load_r0_nostall",  1, 1, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  0, ALL_EN);
        applyStimulus("load_nomatch",     1, 1, 0, 0, 0, 1, 5'd7,  5'd6,  5'd8,  0, ALL_EN);
        applyStimulus("branch_over_lu",   1, 1, 0, 0, 1, 1, 5'd5,  5'd5,  5'd0,  0, BRANCH);
        applyStimulus("branch_nofetch",   1, 0, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, NOFETCH);
        applyStimulus("branch_frozen",    1, 1, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("branch_after_dh",  1, 0, 1, 1, 1, 0, 5'd0,  5'd0,  5'd0,  0, BRANCH);
        applyStimulus("wb_halt",          1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, FREEZE);
`ifdef PIPE_PERF_EN
        checkCounters("cnt_branch", 32'd9, 32'd2, 32'd4);
`endif
        applyStimulus("halted1",          1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, HALTD);
        applyStimulus("halted_branch",    1, 1, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, HALTD);
        applyStimulus("halted3",          1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, HALTD);
`ifdef PIPE_PERF_EN
        checkCounters("cnt_halted", 32'd10, 32'd2, 32'd4);
`endif
        applyStimulus("reset_halted",     0, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("run_after_halt",   1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, ALL_EN);
        applyStimulus("dwait_again",      1, 1, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("reset_in_dwait",   0, 0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, FREEZE);
        applyStimulus("seen_after_rst",   1, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, NOFETCH);
        repeat (3) @(negedge CLK);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
